// File: rtl/branch_history_ctrl.sv
// Dynamic branch predictor: direct-mapped table of 2-bit saturating counters,
// a small FIFO of in-flight predictions, and mispredict detection/recovery.
module branch_history_ctrl #(
    parameter int INDEX_BITS = 4,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        id_branchB,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_branchDst,
    input  logic        ex_branchB,
    input  logic        ex_branchPermit,
    output logic        predict_taken,
    output logic [31:0] pcNext,
    output logic        mispredict,
    output logic [31:0] recover_pc,
    output logic        err_overflow,
    output logic        err_underflow,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_misses
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int CW      = $clog2(QDEPTH + 1);
    // FIFO entry layout: {table index, predicted-taken bit, alternate PC}
    localparam int EW      = INDEX_BITS + 33;

    logic [1:0]            ctr_q [ENTRIES];
    logic [1:0]            ctr_d [ENTRIES];
    logic [EW-1:0]         fifo_q [QDEPTH];
    logic [EW-1:0]         fifo_d [QDEPTH];
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;
    logic [15:0]           stat_br_q, stat_br_d;
    logic [15:0]           stat_ms_q, stat_ms_d;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] head_idx;
    logic                  head_pred;
    logic [31:0]           head_alt;
    logic                  resolve_act;
    logic                  fifo_nonempty;
    logic                  resolve_hit;
    logic                  push_req;
    logic                  lookup_pred;
    logic [EW-1:0]         push_entry;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    assign lookup_idx    = id_pc[INDEX_BITS+1:2];
    assign lookup_pred   = ctr_q[lookup_idx][1];
    assign predict_taken = id_branchB & lookup_pred;

    assign head_idx  = fifo_q[0][EW-1:33];
    assign head_pred = fifo_q[0][32];
    assign head_alt  = fifo_q[0][31:0];

    assign resolve_act   = ex_branchB & ~stall;
    assign fifo_nonempty = (cnt_q != '0);
    assign resolve_hit   = resolve_act & fifo_nonempty;
    assign mispredict    = resolve_hit & (ex_branchPermit != head_pred);
    assign recover_pc    = mispredict ? head_alt : 32'd0;

    // A push from ID while EX mispredicts is wrong-path and is discarded
    assign push_req   = id_branchB & ~stall & ~mispredict;
    assign push_entry = {lookup_idx, lookup_pred,
                         lookup_pred ? (id_pc + 32'd4) : id_branchDst};

    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;
    assign stat_branches = stat_br_q;
    assign stat_misses   = stat_ms_q;

    // Next fetch PC: recovery beats prediction because the ID branch is wrong-path
    always_comb begin
        pcNext = pc + 32'd4;
        if (mispredict) begin
            pcNext = recover_pc;
        end else if (predict_taken) begin
            pcNext = id_branchDst;
        end
    end

    // Next state for table, FIFO, sticky errors and statistics
    always_comb begin
        ctr_d     = ctr_q;
        fifo_d    = fifo_q;
        cnt_d     = cnt_q;
        err_ovf_d = err_ovf_q;
        err_unf_d = err_unf_q;
        stat_br_d = stat_br_q;
        stat_ms_d = stat_ms_q;

        if (resolve_act && !fifo_nonempty) begin
            err_unf_d = 1'b1;
        end

        if (resolve_hit) begin
            ctr_d[head_idx] = ex_branchPermit ? sat_inc(ctr_q[head_idx])
                                              : sat_dec(ctr_q[head_idx]);
            stat_br_d = stat_br_q + 16'd1;
            if (mispredict) begin
                stat_ms_d = stat_ms_q + 16'd1;
            end
        end

        if (mispredict) begin
            cnt_d = '0;
        end else begin
            // Pop first so a push into a full FIFO can take the freed slot
            if (resolve_hit) begin
                for (int i = 0; i < QDEPTH - 1; i++) begin
                    fifo_d[i] = fifo_q[i+1];
                end
                cnt_d = cnt_q - CW'(1);
            end
            if (push_req) begin
                if (cnt_d == CW'(QDEPTH)) begin
                    err_ovf_d = 1'b1;
                end else begin
                    for (int i = 0; i < QDEPTH; i++) begin
                        if (CW'(i) == cnt_d) begin
                            fifo_d[i] = push_entry;
                        end
                    end
                    cnt_d = cnt_d + CW'(1);
                end
            end
        end
    end

    // Control state with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            stat_br_q <= 16'd0;
            stat_ms_q <= 16'd0;
        end else begin
            ctr_q     <= ctr_d;
            cnt_q     <= cnt_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            stat_br_q <= stat_br_d;
            stat_ms_q <= stat_ms_d;
        end
    end

    // FIFO payload; validity is tracked entirely by cnt_q
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

endmodule

// File: tb/tb_branch_history_ctrl.sv
module tb_branch_history_ctrl;

    localparam int IB = 4;
    localparam int QD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0, id_pc = '0, id_branchDst = '0;
    logic        stall = 1'b0, id_branchB = 1'b0, ex_branchB = 1'b0, ex_branchPermit = 1'b0;
    logic        predict_taken, mispredict, err_overflow, err_underflow;
    logic [31:0] pcNext, recover_pc;
    logic [15:0] stat_branches, stat_misses;

    int n_checks = 0;
    int n_fail   = 0;

    branch_history_ctrl #(.INDEX_BITS(IB), .QDEPTH(QD)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .id_branchB(id_branchB), .id_pc(id_pc), .id_branchDst(id_branchDst),
        .ex_branchB(ex_branchB), .ex_branchPermit(ex_branchPermit),
        .predict_taken(predict_taken), .pcNext(pcNext), .mispredict(mispredict),
        .recover_pc(recover_pc), .err_overflow(err_overflow), .err_underflow(err_underflow),
        .stat_branches(stat_branches), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    // Behavioural reference: counters as integers, in-flight predictions as a queue
    typedef struct {
        int          idx;
        bit          pred;
        logic [31:0] alt;
    } ent_t;

    int          m_ctr [1<<IB];
    ent_t        m_q [$];
    bit          m_ovf, m_unf;
    logic [15:0] m_br, m_ms;

    function automatic void model_reset();
        for (int i = 0; i < (1<<IB); i++) m_ctr[i] = 1;
        m_q.delete();
        m_ovf = 0; m_unf = 0; m_br = 0; m_ms = 0;
    endfunction

    function automatic logic [99:0] model_outputs();
        bit p, act, mis;
        logic [31:0] rec, nxt;
        p   = id_branchB && (m_ctr[int'(id_pc[IB+1:2])] >= 2);
        act = ex_branchB && !stall;
        mis = act && (m_q.size() > 0) && (ex_branchPermit != m_q[0].pred);
        rec = mis ? m_q[0].alt : 32'd0;
        nxt = mis ? rec : (p ? id_branchDst : pc + 32'd4);
        return {p, nxt, mis, rec, m_ovf, m_unf, m_br, m_ms};
    endfunction

    function automatic void model_edge();
        bit p, act, mis;
        int hi;
        ent_t e;
        p   = m_ctr[int'(id_pc[IB+1:2])] >= 2;
        act = ex_branchB && !stall;
        mis = act && (m_q.size() > 0) && (ex_branchPermit != m_q[0].pred);
        if (act) begin
            if (m_q.size() == 0) begin
                m_unf = 1;
            end else begin
                hi = m_q[0].idx;
                if (ex_branchPermit) m_ctr[hi] = (m_ctr[hi] < 3) ? m_ctr[hi] + 1 : 3;
                else                 m_ctr[hi] = (m_ctr[hi] > 0) ? m_ctr[hi] - 1 : 0;
                m_br = m_br + 16'd1;
                if (mis) begin
                    m_ms = m_ms + 16'd1;
                    m_q.delete();
                end else begin
                    void'(m_q.pop_front());
                end
            end
        end
        if (id_branchB && !stall && !mis) begin
            if (m_q.size() < QD) begin
                e.idx  = int'(id_pc[IB+1:2]);
                e.pred = p;
                e.alt  = p ? id_pc + 32'd4 : id_branchDst;
                m_q.push_back(e);
            end else begin
                m_ovf = 1;
            end
        end
    endfunction

    task automatic set_in(input logic [31:0] p, input logic s, input logic ib,
                          input logic [31:0] ipc, input logic [31:0] dst,
                          input logic eb, input logic perm);
        pc = p; stall = s; id_branchB = ib; id_pc = ipc; id_branchDst = dst;
        ex_branchB = eb; ex_branchPermit = perm;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        model_reset();
        #7;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] tbl;
        do_reset();
        set_in(32'h44, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({predict_taken, pcNext, mispredict, recover_pc} !== {1'b0, 32'h48, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_comb: got %h expected %h",
                {predict_taken, pcNext, mispredict, recover_pc}, {1'b0, 32'h48, 1'b0, 32'h0});
        end
        n_checks++;
        if ({err_overflow, err_underflow, stat_branches, stat_misses} !== 34'h0) begin
            n_fail++; $display("FAIL reset_regs: got %h expected 0",
                {err_overflow, err_underflow, stat_branches, stat_misses});
        end
        for (int i = 0; i < 16; i++) tbl[2*i +: 2] = dut.ctr_q[i];
        n_checks++;
        if (tbl !== 32'h55555555 || dut.cnt_q !== '0) begin
            n_fail++; $display("FAIL reset_table: got %h cnt %0d expected 55555555 cnt 0", tbl, dut.cnt_q);
        end
        tick();
    endtask

    task automatic test_train();
        do_reset();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0);
        @(negedge clk);
        n_checks++;
        if (predict_taken !== 1'b0 || pcNext !== 32'h48) begin
            n_fail++; $display("FAIL first_predict: got %b/%h expected 0/00000048", predict_taken, pcNext);
        end
        tick();
        set_in(32'h48, 0, 0, 32'h0, 32'h0, 1, 1);
        @(negedge clk);
        n_checks++;
        if ({mispredict, recover_pc, pcNext} !== {1'b1, 32'h100, 32'h100}) begin
            n_fail++; $display("FAIL first_resolve: got %b/%h/%h expected 1/00000100/00000100",
                mispredict, recover_pc, pcNext);
        end
        tick();
        set_in(32'h100, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut.ctr_q[0] !== 2'd2 || stat_misses !== 16'd1 || stat_branches !== 16'd1) begin
            n_fail++; $display("FAIL train_state: got ctr %0d miss %0d br %0d expected 2 1 1",
                dut.ctr_q[0], stat_misses, stat_branches);
        end
    endtask

    task automatic test_saturation();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0);
        @(negedge clk);
        n_checks++;
        if (predict_taken !== 1'b1 || pcNext !== 32'h100) begin
            n_fail++; $display("FAIL taken_predict: got %b/%h expected 1/00000100", predict_taken, pcNext);
        end
        tick();
        for (int k = 0; k < 3; k++) begin
            set_in(32'h100, 0, 1, 32'h40, 32'h100, 1, 1);
            @(negedge clk);
            n_checks++;
            if (mispredict !== 1'b0) begin
                n_fail++; $display("FAIL taken_resolve%0d: got %b expected 0", k, mispredict);
            end
            tick();
        end
        set_in(32'h100, 0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        n_checks++;
        if ({mispredict, recover_pc, dut.ctr_q[0]} !== {1'b1, 32'h44, 2'd3}) begin
            n_fail++; $display("FAIL nottaken_resolve: got %b/%h ctr %0d expected 1/00000044 ctr 3",
                mispredict, recover_pc, dut.ctr_q[0]);
        end
        tick();
        set_in(32'h44, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut.ctr_q[0] !== 2'd2) begin
            n_fail++; $display("FAIL sat_decrement: got %0d expected 2", dut.ctr_q[0]);
        end
    endtask

    task automatic test_flush_underflow();
        do_reset();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0); tick();
        set_in(32'h84, 0, 1, 32'h80, 32'h200, 0, 0); tick();
        set_in(32'h88, 0, 0, 32'h0, 32'h0, 1, 1);
        @(negedge clk);
        n_checks++;
        if (mispredict !== 1'b1 || recover_pc !== 32'h100) begin
            n_fail++; $display("FAIL flush_resolve: got %b/%h expected 1/00000100", mispredict, recover_pc);
        end
        tick();
        set_in(32'h100, 0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (dut.cnt_q !== '0 || mispredict !== 1'b0) begin
            n_fail++; $display("FAIL flush_empty: got cnt %0d mis %b expected 0 0", dut.cnt_q, mispredict);
        end
        tick();
        set_in(32'h104, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if ({err_underflow, stat_branches, stat_misses} !== {1'b1, 16'd1, 16'd1}) begin
            n_fail++; $display("FAIL underflow: got unf %b br %0d miss %0d expected 1 1 1",
                err_underflow, stat_branches, stat_misses);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        set_in(32'h44, 0, 1, 32'h40, 32'h200, 0, 0); tick();
        set_in(32'h48, 0, 1, 32'h44, 32'h204, 0, 0); tick();
        set_in(32'h4c, 0, 1, 32'h48, 32'h208, 0, 0);
        @(negedge clk);
        n_checks++;
        if (err_overflow !== 1'b0 || dut.cnt_q !== 2'd2) begin
            n_fail++; $display("FAIL prefull: got ovf %b cnt %0d expected 0 2", err_overflow, dut.cnt_q);
        end
        tick();
        set_in(32'h50, 0, 1, 32'h4c, 32'h20c, 1, 0);
        @(negedge clk);
        n_checks++;
        if (err_overflow !== 1'b1 || mispredict !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got ovf %b mis %b expected 1 0", err_overflow, mispredict);
        end
        tick();
        set_in(32'h54, 0, 0, 32'h0, 32'h0, 0, 0);
        @(negedge clk);
        n_checks++;
        if (dut.cnt_q !== 2'd2 || stat_branches !== 16'd1 || stat_misses !== 16'd0) begin
            n_fail++; $display("FAIL push_pop_full: got cnt %0d br %0d miss %0d expected 2 1 0",
                dut.cnt_q, stat_branches, stat_misses);
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 3; k++) begin
            set_in(32'h60, 1, 1, 32'h40, 32'h300, 1, 1);
            @(negedge clk);
            n_checks++;
            if (mispredict !== 1'b0 || pcNext !== 32'h64) begin
                n_fail++; $display("FAIL stall_comb%0d: got %b/%h expected 0/00000064", k, mispredict, pcNext);
            end
            tick();
            n_checks++;
            if ({dut.cnt_q, dut.ctr_q[0], stat_branches, stat_misses} !== {2'd2, 2'd0, 16'd1, 16'd0}) begin
                n_fail++; $display("FAIL stall_hold%0d: got cnt %0d ctr %0d br %0d miss %0d expected 2 0 1 0",
                    k, dut.cnt_q, dut.ctr_q[0], stat_branches, stat_misses);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0); tick();
        set_in(32'h100, 0, 0, 32'h0, 32'h0, 1, 1); tick();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0); tick();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 1, 1); tick();
        set_in(32'h44, 0, 1, 32'h40, 32'h100, 0, 0); tick();
        set_in(32'h44, 0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        n_checks++;
        if (dut.cnt_q !== 2'd2 || dut.ctr_q[0] !== 2'd3 || stat_branches !== 16'd2) begin
            n_fail++; $display("FAIL premid: got cnt %0d ctr %0d br %0d expected 2 3 2",
                dut.cnt_q, dut.ctr_q[0], stat_branches);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dut.cnt_q, dut.ctr_q[0], stat_branches, stat_misses, err_overflow, err_underflow, mispredict}
            !== {2'd0, 2'd1, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL async_reset: got cnt %0d ctr %0d br %0d miss %0d ovf %b unf %b mis %b expected 0 1 0 0 0 0 0",
                dut.cnt_q, dut.ctr_q[0], stat_branches, stat_misses, err_overflow, err_underflow, mispredict);
        end
        do_reset();
    endtask

    task automatic test_random();
        logic [99:0] exp_v, got_v;
        logic [31:0] tbl_d, tbl_m;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_in(32'($urandom) & ~32'h3,
                   ($urandom_range(0, 9) == 0),
                   ($urandom_range(0, 1) == 1),
                   32'h40 + 32'($urandom_range(0, 31)) * 32'd4,
                   32'($urandom) & ~32'h3,
                   ($urandom_range(0, 4) < 2),
                   ($urandom_range(0, 1) == 1));
            @(negedge clk);
            exp_v = model_outputs();
            got_v = {predict_taken, pcNext, mispredict, recover_pc,
                     err_overflow, err_underflow, stat_branches, stat_misses};
            n_checks++;
            if (got_v !== exp_v) begin
                n_fail++; $display("FAIL random_out c%0d: got %h expected %h", c, got_v, exp_v);
            end
            for (int i = 0; i < 16; i++) begin
                tbl_d[2*i +: 2] = dut.ctr_q[i];
                tbl_m[2*i +: 2] = 2'(m_ctr[i]);
            end
            n_checks++;
            if (tbl_d !== tbl_m || int'(dut.cnt_q) != m_q.size()) begin
                n_fail++; $display("FAIL random_state c%0d: got %h cnt %0d expected %h cnt %0d",
                    c, tbl_d, dut.cnt_q, tbl_m, m_q.size());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_train();
        test_saturation();
        test_flush_underflow();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_history_ctrl.md
Name: branch_history_ctrl

Overview:
- Dynamic branch predictor and resolution controller for the pipelined CPU's branch-control path.
- Holds a direct-mapped table of 2-bit saturating counters. Predicts conditional branches (B-type) in ID and tracks in-flight predictions in a small FIFO.
- Checks each prediction when EX resolves the branch. On a mispredict it generates a flush and a recovery PC. Keeps hit/miss statistics.

Parameters:
- INDEX_BITS, 4, table index width; table has 2^INDEX_BITS entries indexed by pc[INDEX_BITS+1:2].
- QDEPTH, 2, in-flight prediction FIFO depth (2..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc  in  32  current fetch PC.
- stall  in  1  pipeline stall; when 1, no push and no pop.
- id_branchB  in  1  ID holds a conditional branch.
- id_pc  in  32  PC of the ID branch.
- id_branchDst  in  32  branch target computed in ID.
- ex_branchB  in  1  EX holds a conditional branch being resolved.
- ex_branchPermit  in  1  actual outcome in EX (1 = taken).
- predict_taken  out  1  prediction for the ID branch (combinational).
- pcNext  out  32  next fetch PC suggested by the predictor.
- mispredict  out  1  EX outcome differs from the stored prediction (combinational); also the ID/EX flush request.
- recover_pc  out  32  correct PC when mispredict=1, else 0.
- err_overflow  out  1  sticky: a push was dropped because the FIFO was full.
- err_underflow  out  1  sticky: EX resolved a branch while the FIFO was empty.
- stat_branches  out  16  resolved-branch count, wraps.
- stat_misses  out  16  mispredict count, wraps.

Behaviour:
- Reset (async, rst=1): all counters = 2'b01 (weakly not-taken); FIFO empty; err flags = 0; stats = 0. Combinational outputs follow from this state.
- Lookup:
  - idx = id_pc[INDEX_BITS+1:2].
  - predict_taken = id_branchB & ctr[idx][1].
- pcNext:
  - mispredict=1 → recover_pc.
  - Else predict_taken=1 → id_branchDst.
  - Else → pc+4.
  - Mispredict has priority because the ID branch is wrong-path.
- Push: on a clock edge with id_branchB & !stall & !mispredict, enqueue {idx, predicted bit, alt_pc}.
  - alt_pc = predicted taken ? id_pc+4 : id_branchDst.
  - If the FIFO is full and no pop occurs in the same cycle, drop the push and set err_overflow.
- Resolve:
  - Active when ex_branchB & !stall.
  - FIFO non-empty: compare ex_branchPermit with the head predicted bit.
    - mispredict = active & non-empty & (ex_branchPermit != head.pred).
    - recover_pc = head.alt_pc when mispredict=1, else 0.
  - FIFO empty: no compare, mispredict=0. Set err_underflow on the edge; no table or stats update.
- Update on the resolve edge:
  - ctr[head.idx] saturates: taken → min(ctr+1, 3); not-taken → max(ctr-1, 0).
  - stat_branches += 1.
  - stat_misses += mispredict.
- Pop and flush:
  - Correct prediction: pop the head.
  - Mispredict: clear the whole FIFO. Younger entries are wrong-path, and the same-cycle push is suppressed.
- Simultaneous push and pop without mispredict: occupancy unchanged. A push into a full FIFO is allowed when a pop occurs that cycle.
- Read/write same idx in the same cycle: lookup sees the old counter value; the update lands at the edge.
- Stall: the table, FIFO and stats hold. Combinational outputs are still driven.
- Reset mid-operation: everything returns to reset values immediately, regardless of clk.
- The predictor makes no decision for J-type jumps; the parent block prioritises jumps.

Test Plan:
- Reset, then ID branch at id_pc=0x40 (idx 0), id_branchDst=0x100, pc=0x44. Required: predict_taken=0, pcNext=0x48. Next cycle EX resolves with ex_branchPermit=1. Required: mispredict=1, recover_pc=0x100, pcNext=0x100, ctr[0]=2, stat_misses=1.
- Same branch fetched again. Required: predict_taken=1, pcNext=0x100. Resolve taken. Required: mispredict=0, ctr[0]=3. Two more taken resolutions leave ctr[0]=3 (saturation). One not-taken. Required: mispredict=1, recover_pc=0x44, ctr[0]=2.
- Push branches at 0x40 and 0x80 back-to-back. First resolves as a mispredict. Required: FIFO empty, the 0x80 entry discarded. Next ex_branchB=1 with empty FIFO. Required: mispredict=0, err_underflow=1, stats unchanged.
- QDEPTH=2: three pushes with no resolution. Required: third dropped, err_overflow=1. Then a push and a correct resolve in the same cycle. Required: occupancy stays 2.
- stall=1 with id_branchB=1 and ex_branchB=1 for 3 cycles. Required: FIFO, ctr and stats unchanged.
- Assert rst mid-stream (FIFO holds 2 entries, ctr[0]=3). Required: immediately FIFO empty, ctr[0]=1, stats=0, err flags=0.
